// File: rtl/pic_inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer: synchronizes the PIC INT line, issues the
// two INTA pulses, captures the vector byte on pulse 2 and offers it to the CPU via valid/ready.
module pic_inta_sequencer #(
   parameter int INT_SYNC_STAGES = 2,
   parameter int INTA_LOW_CYCLES = 2,
   parameter int INTA_GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       INT,
   input  logic       int_enable,
   input  logic [7:0] sys_DataLine,
   output logic       INTA,
   output logic [7:0] vector,
   output logic       vector_valid,
   input  logic       vector_ready,
   output logic       busy
);

   localparam int LOW_GAP_MAX = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
   localparam int CNT_MAX     = (LOW_GAP_MAX > INT_SYNC_STAGES + 1) ? LOW_GAP_MAX : INT_SYNC_STAGES + 1;
   localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] LOW_LD = CNT_W'(INTA_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(INTA_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LD = CNT_W'(INT_SYNC_STAGES);

   typedef enum logic [2:0] {
      IDLE,
      PULSE1,
      GAP,
      PULSE2,
      HOLD,
      RECOVER
   } state_t;

   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic [INT_SYNC_STAGES-1:0] int_sync;
   logic                       int_s;

   // INT synchronizer; int_s is the last stage
   always_ff @(posedge clk) begin
      if (rst) begin
         int_sync <= '0;
      end else begin
         int_sync <= {int_sync[INT_SYNC_STAGES-2:0], INT};
      end
   end

   assign int_s = int_sync[INT_SYNC_STAGES-1];

   // Sequencer: every output is registered so INTA cannot glitch; cnt counts down to 0 per state
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         INTA         <= 1'b1;
         vector       <= 8'h00;
         vector_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (int_s && int_enable) begin
                  state <= PULSE1;
                  cnt   <= LOW_LD;
                  INTA  <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            PULSE1: begin
               if (cnt == '0) begin
                  state <= GAP;
                  cnt   <= GAP_LD;
                  INTA  <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= PULSE2;
                  cnt   <= LOW_LD;
                  INTA  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            PULSE2: begin
               if (cnt == '0) begin
                  state        <= HOLD;
                  cnt          <= '0;
                  INTA         <= 1'b1;
                  vector       <= sys_DataLine;
                  vector_valid <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (vector_ready) begin
                  state        <= RECOVER;
                  cnt          <= REC_LD;
                  vector_valid <= 1'b0;
               end
            end
            RECOVER: begin
               // Long enough for an int_s already in flight to drain before IDLE samples it
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state        <= IDLE;
               cnt          <= '0;
               INTA         <= 1'b1;
               vector_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: a timeline model predicts per-cycle outputs and
// transferred vectors; a monitor compares them against the DUT.
module tb_pic_inta_sequencer;

   localparam int S = 2;
   localparam int L = 2;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       INT = 1'b0;
   logic       int_enable = 1'b0;
   logic [7:0] sys_DataLine = 8'h00;
   logic       vector_ready = 1'b0;
   logic       INTA;
   logic [7:0] vector;
   logic       vector_valid;
   logic       busy;

   always #5 clk = ~clk;

   pic_inta_sequencer #(
      .INT_SYNC_STAGES(S),
      .INTA_LOW_CYCLES(L),
      .INTA_GAP_CYCLES(G)
   ) dut (
      .clk(clk),
      .rst(rst),
      .INT(INT),
      .int_enable(int_enable),
      .sys_DataLine(sys_DataLine),
      .INTA(INTA),
      .vector(vector),
      .vector_valid(vector_valid),
      .vector_ready(vector_ready),
      .busy(busy)
   );

   typedef struct packed {
      logic       inta;
      logic       busy;
      logic       vv;
      logic [7:0] vec;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] vec_q[$];
   int         checks = 0;
   int         fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: the sequence is described by the edge index at which it started
   typedef enum {M_IDLE, M_SEQ, M_HOLD, M_REC} mode_t;
   mode_t      m_mode = M_IDLE;
   int         k = 0;
   int         s_edge = 0;
   int         x_edge = 0;
   int         last_rst = 0;
   logic [7:0] m_vec = 8'h00;
   logic       int_at[0:16383];

   function automatic logic int_s_seen(input int e);
      if (e - S >= last_rst + 1) return int_at[e-S];
      return 1'b0;
   endfunction

   task automatic model_edge();
      exp_t e;
      int   d;
      int_at[k] = INT;
      if (rst) begin
         m_mode   = M_IDLE;
         last_rst = k;
         m_vec    = 8'h00;
         vec_q.delete();
      end else begin
         case (m_mode)
            M_IDLE: if (int_s_seen(k) && int_enable) begin m_mode = M_SEQ; s_edge = k; end
            M_SEQ: if (k == s_edge + 2*L + G) begin
               m_vec = sys_DataLine;
               vec_q.push_back(sys_DataLine);
               m_mode = M_HOLD;
            end
            M_HOLD: if (vector_ready) begin m_mode = M_REC; x_edge = k; end
            M_REC: if (k == x_edge + S + 1) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
         endcase
      end
      e.vec  = m_vec;
      e.inta = 1'b1;
      e.busy = (m_mode != M_IDLE);
      e.vv   = (m_mode == M_HOLD);
      if (m_mode == M_SEQ) begin
         d = k - s_edge;
         if (d < L || (d >= L + G && d < 2*L + G)) e.inta = 1'b0;
      end
      exp_q.push_back(e);
      k++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Monitor: per-cycle outputs, plus the vector on every handshake
   initial begin
      exp_t e;
      logic [7:0] v;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("INTA", {31'b0, INTA}, {31'b0, e.inta});
            check("busy", {31'b0, busy}, {31'b0, e.busy});
            check("vector_valid", {31'b0, vector_valid}, {31'b0, e.vv});
            check("vector", {24'b0, vector}, {24'b0, e.vec});
         end
         if (!rst && vector_valid === 1'b1 && vector_ready) begin
            if (vec_q.size() == 0) begin
               check("spurious_transfer", 32'd1, 32'd0);
            end else begin
               v = vec_q.pop_front();
               check("xfer_vector", {24'b0, vector}, {24'b0, v});
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (vector_valid !== 1'b1 && n < 60) begin tick(); n++; end
      if (vector_valid !== 1'b1) check(name, 32'd0, 32'd1);
   endtask

   initial begin
      // Basic sequence with vector 4B
      rst = 1'b1; INT = 1'b0; int_enable = 1'b0; vector_ready = 1'b0;
      do_reset();
      INT = 1'b1; int_enable = 1'b1; sys_DataLine = 8'h4B; vector_ready = 1'b1;
      repeat (12) tick();
      INT = 1'b0;
      repeat (12) tick();

      // CPU stalls for 5 cycles
      do_reset();
      vector_ready = 1'b0; INT = 1'b1; sys_DataLine = 8'h4B;
      wait_valid("stall_valid_timeout");
      INT = 1'b0;
      repeat (5) tick();
      vector_ready = 1'b1;
      repeat (12) tick();

      // Interrupts masked, then enabled
      do_reset();
      int_enable = 1'b0; INT = 1'b1;
      repeat (20) tick();
      int_enable = 1'b1;
      repeat (6) tick();
      INT = 1'b0;
      repeat (14) tick();

      // INT dropped during GAP
      do_reset();
      INT = 1'b1; sys_DataLine = 8'h5A;
      repeat (5) tick();
      INT = 1'b0;
      repeat (15) tick();

      // Reset during PULSE2, INT still high
      do_reset();
      INT = 1'b1; sys_DataLine = 8'h77;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (14) tick();
      INT = 1'b0;
      repeat (12) tick();

      // Two back-to-back interrupts with INT held high
      do_reset();
      INT = 1'b1; sys_DataLine = 8'h20;
      wait_valid("first_valid_timeout");
      sys_DataLine = 8'h21;
      tick();
      wait_valid("second_valid_timeout");
      INT = 1'b0;
      repeat (12) tick();

      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         rst          = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 9) == 0) INT = ~INT;
         int_enable   = ($urandom_range(0, 7) != 0);
         vector_ready = ($urandom_range(0, 2) != 0);
         sys_DataLine = 8'($urandom);
         tick();
      end

      // Drain: every captured vector must be transferred
      rst = 1'b0; INT = 1'b0; vector_ready = 1'b1;
      repeat (30) tick();
      check("undelivered_vectors", vec_q.size(), 32'd0);
      repeat (2) @(negedge clk);
      check("unchecked_cycles", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
